// File: rtl/commit_ctrl_pkg.sv
// Shared widths, state encoding and tag constants for the commit sequencer.
package commit_ctrl_pkg;

  localparam int unsigned NAME_W_D = 5;
  localparam int unsigned NICK_W_D = 4;
  localparam int unsigned DATA_W_D = 32;
  localparam int unsigned ADDR_W_D = 32;

  typedef logic [NAME_W_D-1:0] NameBus;
  typedef logic [NICK_W_D-1:0] NickBus;
  typedef logic [DATA_W_D-1:0] DataBus;
  typedef logic [ADDR_W_D-1:0] AddrBus;

  // Tag value meaning "no rename outstanding".
  localparam int unsigned NICK_NONE = 0;

  typedef enum logic [1:0] {
    IDLE,
    ST_WAIT,
    FLUSH
  } state_t;

endpackage

// File: rtl/commit_ctrl_flush_timer.sv
// Loadable countdown that advances only on rdy cycles; last flags the final count.
module commit_ctrl_flush_timer #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (rdy) begin
      if (load) begin
        cnt <= load_val;
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/commit_ctrl.sv
// ROB-head retirement sequencer: RF commit, store hand-off to the LSB, mispredict flush/redirect.
module commit_ctrl
  import commit_ctrl_pkg::*;
#(
  parameter int unsigned NAME_W    = NAME_W_D,
  parameter int unsigned NICK_W    = NICK_W_D,
  parameter int unsigned DATA_W    = DATA_W_D,
  parameter int unsigned ADDR_W    = ADDR_W_D,
  parameter int unsigned FLUSH_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              iROB_hd_valid,
  input  logic              iROB_hd_ready,
  input  logic [NICK_W-1:0] iROB_hd_nick,
  input  logic [NAME_W-1:0] iROB_hd_regnm,
  input  logic [DATA_W-1:0] iROB_hd_dt,
  input  logic              iROB_hd_store,
  input  logic              iROB_hd_mispred,
  input  logic [ADDR_W-1:0] iROB_hd_tgt,
  output logic              oROB_pop,
  output logic              oRF_en,
  output logic [NAME_W-1:0] oRF_regnm,
  output logic [DATA_W-1:0] oRF_dt,
  output logic [NICK_W-1:0] oRF_nick,
  output logic              oLSB_st_en,
  output logic [NICK_W-1:0] oLSB_st_nick,
  input  logic              iLSB_st_done,
  output logic              oClr,
  output logic              oPC_redir_en,
  output logic [ADDR_W-1:0] oPC_redir,
  output logic [31:0]       oCommit_cnt
);

  localparam int unsigned FL_W = $clog2(FLUSH_CYC + 1);

  state_t            state, state_nx;
  logic [31:0]       commit_cnt;
  logic [NICK_W-1:0] st_nick_q;
  logic              live;
  logic              commit;
  logic              st_latch;
  logic              flush_load;
  logic              flush_last;

  assign live   = rdy & ~rst;
  assign commit = iROB_hd_valid & iROB_hd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      commit_cnt <= '0;
      st_nick_q  <= NICK_W'(NICK_NONE);
    end else begin
      state <= state_nx;
      if (oROB_pop) commit_cnt <= commit_cnt + 32'd1;
      if (st_latch) st_nick_q <= iROB_hd_nick;
    end
  end

  // Everything is gated by live, so a frozen or resetting block shows all-zero outputs.
  always_comb begin
    state_nx     = state;
    oROB_pop     = 1'b0;
    oRF_en       = 1'b0;
    oRF_regnm    = '0;
    oRF_dt       = '0;
    oRF_nick     = '0;
    oLSB_st_en   = 1'b0;
    oLSB_st_nick = '0;
    oClr         = 1'b0;
    oPC_redir_en = 1'b0;
    oPC_redir    = '0;
    st_latch     = 1'b0;
    flush_load   = 1'b0;
    if (live) begin
      unique case (state)
        IDLE: begin
          if (commit) begin
            if (iROB_hd_store) begin
              oLSB_st_en   = 1'b1;
              oLSB_st_nick = iROB_hd_nick;
              st_latch     = 1'b1;
              state_nx     = ST_WAIT;
            end else begin
              oROB_pop = 1'b1;
              if (iROB_hd_regnm != '0) begin
                oRF_en    = 1'b1;
                oRF_regnm = iROB_hd_regnm;
                oRF_dt    = iROB_hd_dt;
                oRF_nick  = iROB_hd_nick;
              end
              if (iROB_hd_mispred) begin
                oClr         = 1'b1;
                oPC_redir_en = 1'b1;
                oPC_redir    = iROB_hd_tgt;
                flush_load   = 1'b1;
                state_nx     = FLUSH;
              end
            end
          end
        end
        ST_WAIT: begin
          oLSB_st_nick = st_nick_q;
          if (iLSB_st_done) begin
            oROB_pop = 1'b1;
            state_nx = IDLE;
          end
        end
        FLUSH: begin
          oClr = 1'b1;
          if (flush_last) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign oCommit_cnt = rst ? '0 : commit_cnt;

  commit_ctrl_flush_timer #(
    .CNT_W(FL_W)
  ) u_flush_timer (
    .clk     (clk),
    .rst     (rst),
    .rdy     (rdy),
    .load    (flush_load),
    .load_val(FL_W'(FLUSH_CYC)),
    .last    (flush_last)
  );

endmodule

// File: tb/tb_commit_ctrl.sv
// Bench for commit_ctrl: directed scenarios with literal expectations plus a random phase, all checked against a behavioural model.
module tb_commit_ctrl;

  localparam int unsigned FLUSH_CYC = 2;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        hd_valid, hd_ready, hd_store, hd_mispred, st_done;
  logic [3:0]  hd_nick;
  logic [4:0]  hd_regnm;
  logic [31:0] hd_dt, hd_tgt;
  logic        pop, rf_en, st_en, clr, redir_en;
  logic [4:0]  rf_regnm;
  logic [31:0] rf_dt, redir, cnt;
  logic [3:0]  rf_nick, st_nick;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Behavioural model state
  bit          m_store_wait = 0;
  logic [3:0]  m_st_nick = '0;
  int          m_flush_left = 0;
  logic [31:0] m_cnt = '0;

  always #5 clk = ~clk;

  commit_ctrl #(
    .NAME_W(5), .NICK_W(4), .DATA_W(32), .ADDR_W(32), .FLUSH_CYC(FLUSH_CYC)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .iROB_hd_valid(hd_valid), .iROB_hd_ready(hd_ready), .iROB_hd_nick(hd_nick),
    .iROB_hd_regnm(hd_regnm), .iROB_hd_dt(hd_dt), .iROB_hd_store(hd_store),
    .iROB_hd_mispred(hd_mispred), .iROB_hd_tgt(hd_tgt),
    .oROB_pop(pop), .oRF_en(rf_en), .oRF_regnm(rf_regnm), .oRF_dt(rf_dt), .oRF_nick(rf_nick),
    .oLSB_st_en(st_en), .oLSB_st_nick(st_nick), .iLSB_st_done(st_done),
    .oClr(clr), .oPC_redir_en(redir_en), .oPC_redir(redir), .oCommit_cnt(cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Model compare: outputs settle half a cycle after inputs change.
  always @(negedge clk) begin
    logic        e_pop, e_rf_en, e_st_en, e_clr, e_redir_en;
    logic [4:0]  e_regnm;
    logic [31:0] e_dt, e_redir, e_cnt;
    logic [3:0]  e_nick, e_st_nick;
    e_pop = 0; e_rf_en = 0; e_st_en = 0; e_clr = 0; e_redir_en = 0;
    e_regnm = '0; e_dt = '0; e_redir = '0; e_nick = '0; e_st_nick = '0;
    e_cnt = rst ? 32'd0 : m_cnt;
    if (!rst && rdy) begin
      if (m_store_wait) begin
        e_st_nick = m_st_nick;
        e_pop = st_done;
      end else if (m_flush_left > 0) begin
        e_clr = 1;
      end else if (hd_valid && hd_ready) begin
        if (hd_store) begin
          e_st_en = 1;
          e_st_nick = hd_nick;
        end else begin
          e_pop = 1;
          if (hd_regnm != 0) begin
            e_rf_en = 1; e_regnm = hd_regnm; e_dt = hd_dt; e_nick = hd_nick;
          end
          if (hd_mispred) begin
            e_clr = 1; e_redir_en = 1; e_redir = hd_tgt;
          end
        end
      end
    end
    chk("pop", 64'(pop), 64'(e_pop));
    chk("rf_en", 64'(rf_en), 64'(e_rf_en));
    chk("rf_regnm", 64'(rf_regnm), 64'(e_regnm));
    chk("rf_dt", 64'(rf_dt), 64'(e_dt));
    chk("rf_nick", 64'(rf_nick), 64'(e_nick));
    chk("st_en", 64'(st_en), 64'(e_st_en));
    chk("st_nick", 64'(st_nick), 64'(e_st_nick));
    chk("clr", 64'(clr), 64'(e_clr));
    chk("redir_en", 64'(redir_en), 64'(e_redir_en));
    chk("redir", 64'(redir), 64'(e_redir));
    chk("commit_cnt", 64'(cnt), 64'(e_cnt));
    // advance model to the state the next clock edge produces
    if (rst) begin
      m_store_wait = 0; m_st_nick = '0; m_flush_left = 0; m_cnt = '0;
    end else if (rdy) begin
      if (m_store_wait) begin
        if (st_done) m_store_wait = 0;
      end else if (m_flush_left > 0) begin
        m_flush_left--;
      end else if (hd_valid && hd_ready) begin
        if (hd_store) begin
          m_store_wait = 1; m_st_nick = hd_nick;
        end else if (hd_mispred) begin
          m_flush_left = FLUSH_CYC;
        end
      end
      if (e_pop) m_cnt = m_cnt + 32'd1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_hd(input logic v, input logic r, input logic [3:0] nk, input logic [4:0] rn,
                        input logic [31:0] dt, input logic st, input logic mp, input logic [31:0] tg);
    hd_valid = v; hd_ready = r; hd_nick = nk; hd_regnm = rn;
    hd_dt = dt; hd_store = st; hd_mispred = mp; hd_tgt = tg;
  endtask

  task automatic idle_hd();
    set_hd(0, 0, 4'd0, 5'd0, 32'd0, 0, 0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; rdy = 1; st_done = 0;
    idle_hd();
    @(negedge clk);
    chk("lit_reset_cnt", 64'(cnt), 64'd0);
    chk("lit_reset_pop", 64'(pop), 64'd0);

    // Three back-to-back ready entries
    cyc(); rst = 0; set_hd(1, 1, 4'd3, 5'd5, 32'h11, 0, 0, 32'd0);
    @(negedge clk);
    chk("lit_x5_pop", 64'(pop), 64'd1);
    chk("lit_x5_rf", {32'(rf_en), 27'd0, rf_regnm}, {32'd1, 27'd0, 5'd5});
    chk("lit_x5_dt", 64'(rf_dt), 64'h11);
    cyc(); set_hd(1, 1, 4'd4, 5'd0, 32'h99, 0, 0, 32'd0);
    @(negedge clk);
    chk("lit_x0_pop", 64'(pop), 64'd1);
    chk("lit_x0_rf_en", 64'(rf_en), 64'd0);
    cyc(); set_hd(1, 1, 4'd5, 5'd6, 32'h22, 0, 0, 32'd0);
    @(negedge clk);
    chk("lit_x6_rf", {32'(rf_en), 27'd0, rf_regnm}, {32'd1, 27'd0, 5'd6});
    chk("lit_x6_nick", 64'(rf_nick), 64'd5);
    cyc(); idle_hd();
    @(negedge clk);
    chk("lit_cnt3", 64'(cnt), 64'd3);

    // Store with LSB done four cycles later
    cyc(); set_hd(1, 1, 4'd7, 5'd9, 32'h0, 1, 0, 32'd0);
    @(negedge clk);
    chk("lit_st_en", 64'(st_en), 64'd1);
    chk("lit_st_nick", 64'(st_nick), 64'd7);
    chk("lit_st_nopop", 64'(pop), 64'd0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      @(negedge clk);
      chk("lit_st_wait_en", 64'(st_en), 64'd0);
      chk("lit_st_wait_pop", 64'(pop), 64'd0);
    end
    cyc(); st_done = 1;
    @(negedge clk);
    chk("lit_st_done_pop", 64'(pop), 64'd1);
    cyc(); st_done = 0; idle_hd();
    @(negedge clk);
    chk("lit_cnt4", 64'(cnt), 64'd4);

    // JALR mispredict
    cyc(); set_hd(1, 1, 4'd2, 5'd1, 32'h104, 0, 1, 32'h200);
    @(negedge clk);
    chk("lit_mp_rf", {32'(rf_en), 27'd0, rf_regnm}, {32'd1, 27'd0, 5'd1});
    chk("lit_mp_dt", 64'(rf_dt), 64'h104);
    chk("lit_mp_clr_redir", {32'(clr), 31'd0, redir_en}, {32'd1, 32'd1});
    chk("lit_mp_tgt", 64'(redir), 64'h200);
    cyc(); idle_hd();
    @(negedge clk);
    chk("lit_fl1_clr", 64'(clr), 64'd1);
    chk("lit_fl1_redir_en", 64'(redir_en), 64'd0);
    cyc();
    @(negedge clk);
    chk("lit_fl2_clr", 64'(clr), 64'd1);
    cyc();
    @(negedge clk);
    chk("lit_fl_end_clr", 64'(clr), 64'd0);
    chk("lit_cnt5", 64'(cnt), 64'd5);

    // Mispredict with rdy dropped mid-flush; a ready head waits behind it
    cyc(); set_hd(1, 1, 4'd6, 5'd0, 32'h0, 0, 1, 32'h300);
    @(negedge clk);
    chk("lit_mp2_clr", 64'(clr), 64'd1);
    chk("lit_mp2_rf_en", 64'(rf_en), 64'd0);
    cyc(); set_hd(1, 1, 4'd1, 5'd7, 32'h77, 0, 0, 32'd0);
    @(negedge clk);
    chk("lit_fl_a_clr", 64'(clr), 64'd1);
    chk("lit_fl_a_pop", 64'(pop), 64'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(); rdy = 0;
      @(negedge clk);
      chk("lit_frz_clr", 64'(clr), 64'd0);
      chk("lit_frz_pop", 64'(pop), 64'd0);
      chk("lit_frz_cnt", 64'(cnt), 64'd6);
    end
    cyc(); rdy = 1;
    @(negedge clk);
    chk("lit_fl_b_clr", 64'(clr), 64'd1);
    chk("lit_fl_b_pop", 64'(pop), 64'd0);
    cyc();
    @(negedge clk);
    chk("lit_after_fl_clr", 64'(clr), 64'd0);
    chk("lit_after_fl_pop", 64'(pop), 64'd1);
    chk("lit_after_fl_rn", 64'(rf_regnm), 64'd7);
    cyc(); idle_hd();
    @(negedge clk);
    chk("lit_cnt7", 64'(cnt), 64'd7);

    // Reset while waiting for a store, then a stale done
    cyc(); set_hd(1, 1, 4'd9, 5'd0, 32'h0, 1, 0, 32'd0);
    @(negedge clk);
    chk("lit_st2_en", 64'(st_en), 64'd1);
    cyc(); rst = 1; idle_hd();
    @(negedge clk);
    chk("lit_rst_cnt", 64'(cnt), 64'd0);
    chk("lit_rst_nick", 64'(st_nick), 64'd0);
    cyc(); st_done = 1;
    @(negedge clk);
    chk("lit_rst_done_pop", 64'(pop), 64'd0);
    cyc(); rst = 0;
    @(negedge clk);
    chk("lit_stale_done_pop", 64'(pop), 64'd0);
    chk("lit_stale_done_cnt", 64'(cnt), 64'd0);
    cyc(); st_done = 0;

    // Counter wrap
    force dut.commit_cnt = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    #1 release dut.commit_cnt;
    @(negedge clk);
    chk("lit_preset_cnt", 64'(cnt), 64'hFFFF_FFFF);
    cyc(); set_hd(1, 1, 4'd3, 5'd3, 32'h33, 0, 0, 32'd0);
    @(negedge clk);
    chk("lit_wrap_pop", 64'(pop), 64'd1);
    cyc(); idle_hd();
    @(negedge clk);
    chk("lit_wrap_cnt", 64'(cnt), 64'd0);

    // Random phase
    for (int i = 0; i < 2000; i++) begin
      cyc();
      rst        = ($urandom_range(0, 99) < 2);
      rdy        = ($urandom_range(0, 99) < 85);
      hd_valid   = ($urandom_range(0, 99) < 80);
      hd_ready   = ($urandom_range(0, 99) < 75);
      hd_store   = ($urandom_range(0, 99) < 15);
      hd_mispred = ($urandom_range(0, 99) < 10);
      hd_nick    = 4'($urandom_range(0, 15));
      hd_regnm   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      hd_dt      = $urandom;
      hd_tgt     = $urandom;
      st_done    = ($urandom_range(0, 99) < 30);
    end

    cyc(); rst = 0; rdy = 1; st_done = 0; idle_hd();
    @(negedge clk);
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/commit_ctrl.md
Name: commit_ctrl

Overview:
- Retirement sequencer between the ROB head and the architectural register file / load-store buffer of the out-of-order RISC-V core.
- Each cycle it decides whether the head entry retires:
  - drives the register file commit port (regnm/data/nick);
  - holds stores until the LSB confirms the memory write;
  - on branch/JALR mispredict, raises the global clr pulse train and the PC redirect.
- Single commit per cycle.

Parameters:
- NAME_W, 5, architectural register index width
- NICK_W, 4, ROB tag (nick) width; nick 0 means "no rename"
- DATA_W, 32, register data width
- ADDR_W, 32, PC width
- FLUSH_CYC, 2, extra cycles clr stays high after the mispredict commit cycle (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; low freezes the block
- iROB_hd_valid  in  1  ROB head entry exists
- iROB_hd_ready  in  1  head result is complete
- iROB_hd_nick  in  NICK_W  head tag
- iROB_hd_regnm  in  NAME_W  destination register (0 = none)
- iROB_hd_dt  in  DATA_W  result data
- iROB_hd_store  in  1  head is SB/SH/SW
- iROB_hd_mispred  in  1  head is a branch/JALR whose prediction was wrong
- iROB_hd_tgt  in  ADDR_W  correct next PC for a mispredict
- oROB_pop  out  1  head retires this cycle
- oRF_en  out  1  register file commit write
- oRF_regnm  out  NAME_W  commit register
- oRF_dt  out  DATA_W  commit data
- oRF_nick  out  NICK_W  commit tag (regfile clears the rename only if the tag matches)
- oLSB_st_en  out  1  one-cycle request: perform the store tagged oLSB_st_nick
- oLSB_st_nick  out  NICK_W  store tag
- iLSB_st_done  in  1  store written to memory
- oClr  out  1  global pipeline flush
- oPC_redir_en  out  1  one-cycle redirect pulse
- oPC_redir  out  ADDR_W  redirect target
- oCommit_cnt  out  32  retired-instruction counter

Behaviour:
- States: IDLE, ST_WAIT, FLUSH. All outputs are combinational from state and head inputs; state, counters and latched fields are registered.
- rst (sync): state = IDLE, flush counter = 0, oCommit_cnt = 0, latched tag = 0. While rst is high all outputs are 0.
- rdy low: state and counters hold; every output is 0 except oCommit_cnt. oClr also reads 0 and the flush countdown pauses.
- IDLE: commit condition is hd_valid & hd_ready.
  - Normal entry (not store, not mispred): oROB_pop = 1 and oCommit_cnt + 1. If regnm != 0 then oRF_en = 1 with regnm/dt/nick; if regnm == 0, oRF_en = 0.
  - Store: oLSB_st_en = 1 and oLSB_st_nick = hd_nick; latch the nick; go to ST_WAIT. No pop.
  - Mispredict: pop, count, and do the RF write exactly as a normal entry (covers JALR rd). In the same cycle oClr = 1, oPC_redir_en = 1, oPC_redir = hd_tgt. Load counter = FLUSH_CYC and go to FLUSH. The regfile sees write and clr together and must keep the data.
  - Otherwise all outputs are 0.
- ST_WAIT: wait for iLSB_st_done. The head stays stable and hd_* are ignored.
  - On done: oROB_pop = 1, count + 1, go to IDLE. The next commit starts the following cycle at the earliest.
  - oLSB_st_en is never re-asserted here.
- FLUSH: oClr = 1 and counter decrements each rdy cycle. When counter == 1, clr is still high that cycle and the next state is IDLE. No pops or writes while in FLUSH.
- Throughput: 1 commit/cycle for back-to-back ready non-store entries. A store costs 1 + LSB latency cycles. A mispredict makes the core lose 1 + FLUSH_CYC cycles.
- oCommit_cnt wraps modulo 2^32.
- Reset mid-ST_WAIT or mid-FLUSH: go immediately to IDLE with clr low. A store-done arriving later is ignored.
- iLSB_st_done in IDLE or FLUSH is ignored.
- hd_store and hd_mispred both set: treat as store (mispred is ignored; the ROB guarantees exclusivity).

Decomposition:
- Shared package/config: NameBus, NickBus, DataBus, AddrBus widths; state encodings; NICK_NONE = 0.
- Natural sub-module: flush_timer (load, decrement on rdy, done flag), reusable for other flush sources.

Test Plan:
- Three ready entries (x5=0x11 nick 3; x0 nick 4; x6=0x22 nick 5) -> pops in 3 consecutive cycles. oRF_en = 1 for x5 and x6 only. oCommit_cnt goes 0 to 3.
- Store head nick 7, done after 4 cycles -> oLSB_st_en for 1 cycle with nick 7. Pop in the done cycle. oCommit_cnt + 1 once.
- JALR mispredict, rd=x1, dt=0x104, tgt=0x200, FLUSH_CYC=2 -> same cycle: RF write x1=0x104, oClr = 1, redirect 0x200. oClr stays high 2 more cycles, then IDLE.
- rdy dropped for 3 cycles during FLUSH -> all outputs 0, countdown paused. After rdy returns, oClr is high the remaining cycles only.
- rst asserted in ST_WAIT, then done pulses -> after reset: IDLE, no pop, oCommit_cnt = 0.
- oCommit_cnt preset 0xFFFFFFFF (forced), one commit -> oCommit_cnt = 0.
